// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment value decoder: active-low digit patterns
// on segments {g,f,e,d,c,b,a}, the all-off blank pattern, and the FSM state type.
package seg_pkg;

    localparam int unsigned VALUE_W_DEFAULT = 20;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational seven-segment pattern to BCD digit decoder.
// Define SEG_BLANK_ZERO_EN to accept the blank pattern as digit 0 without error.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       invalid
);

    always_comb begin
        digit   = 4'd0;
        invalid = 1'b0;
        case (seg)
            SEG_0: digit = 4'd0;
            SEG_1: digit = 4'd1;
            SEG_2: digit = 4'd2;
            SEG_3: digit = 4'd3;
            SEG_4: digit = 4'd4;
            SEG_5: digit = 4'd5;
            SEG_6: digit = 4'd6;
            SEG_7: digit = 4'd7;
            SEG_8: digit = 4'd8;
            SEG_9: digit = 4'd9;
`ifdef SEG_BLANK_ZERO_EN
            SEG_BLANK: digit = 4'd0;
`endif
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_value_decoder.sv
// Accumulates a frame of NUM_DIGITS seven-segment patterns (MS digit first) into a
// binary value with a sticky error flag. Optional feature macro: SEG_BLANK_ZERO_EN.
module seg_value_decoder
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VALUE_W    = VALUE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         seg_in,
    input  logic               seg_valid,
    output logic               seg_ready,
    input  logic               clear,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    input  logic               value_ready,
    output logic               err
);

    localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

    state_e              state_q;
    logic [VALUE_W-1:0]  acc_q;
    logic [VALUE_W-1:0]  value_q;
    logic [CntW-1:0]     cnt_q;
    logic                err_q;
    logic                err_out_q;
    logic                valid_q;

    logic [3:0]          digit;
    logic                invalid;
    logic                seg_fire;
    logic                last_digit;
    logic [VALUE_W-1:0]  acc_d;
    logic                err_d;
    logic                unused_dp;

    assign unused_dp = seg_in[7];

    seg_digit_decode u_decode (
        .seg     (seg_in[6:0]),
        .digit   (digit),
        .invalid (invalid)
    );

    assign seg_ready  = (state_q != StDone);
    assign seg_fire   = seg_valid && seg_ready;
    assign last_digit = (cnt_q == CntW'(NUM_DIGITS - 1));
    // Truncation to VALUE_W gives the modulo-2^VALUE_W accumulation.
    assign acc_d      = acc_q * VALUE_W'(10) + VALUE_W'(digit);
    assign err_d      = err_q | invalid;

    always_ff @(posedge clk) begin
        // Clear behaves exactly like reset and wins over any handshake.
        if (!rst_n || clear) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            value_q   <= '0;
            err_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    if (seg_fire) begin
                        acc_q <= acc_d;
                        err_q <= err_d;
                        cnt_q <= cnt_q + CntW'(1);
                        if (last_digit) begin
                            state_q   <= StDone;
                            value_q   <= acc_d;
                            err_out_q <= err_d;
                            valid_q   <= 1'b1;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StDone: begin
                    if (value_ready) begin
                        state_q   <= StIdle;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        value_q   <= '0;
                        err_out_q <= 1'b0;
                        valid_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign value       = value_q;
    assign err         = err_out_q;
    assign value_valid = valid_q;

endmodule

// File: tb/tb_seg_value_decoder.sv
// Self-checking bench for seg_value_decoder: directed frame table, abort/reset
// sequences and randomized frames checked against a digit-lookup reference model.
module tb_seg_value_decoder;

    localparam int NumDigits = 6;
    localparam int ValueW    = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        seg_in = 8'h00;
    logic              seg_valid = 1'b0;
    logic              seg_ready;
    logic              clear = 1'b0;
    logic [ValueW-1:0] value;
    logic              value_valid;
    logic              value_ready = 1'b0;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [5:0][7:0]   pats;  // [5] is sent first
        logic [7:0]        gap;
        logic [7:0]        hold;
        logic [ValueW-1:0] ev;
        logic              ee;
    } vec_t;

    vec_t vecs [4];

    seg_value_decoder #(
        .NUM_DIGITS (NumDigits),
        .VALUE_W    (ValueW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .clear       (clear),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: look the pattern up in the digit table; unknown patterns are 0 and bad.
    function automatic void ref_digit(input logic [7:0] p, output int d, output bit bad);
        d   = 0;
        bad = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (p[6:0] == pat_tab[i]) begin
                d   = i;
                bad = 1'b0;
            end
        end
`ifdef SEG_BLANK_ZERO_EN
        if (p[6:0] == 7'h7F) bad = 1'b0;
`endif
    endfunction

    function automatic void ref_frame(input logic [5:0][7:0] pats,
                                      output logic [ValueW-1:0] v, output bit e);
        longint acc = 0;
        int     d;
        bit     bad;
        e = 1'b0;
        for (int i = NumDigits - 1; i >= 0; i--) begin
            ref_digit(pats[i], d, bad);
            acc = (acc * 10 + d) % (longint'(1) << ValueW);
            e   = e | bad;
        end
        v = ValueW'(acc);
    endfunction

    task automatic send_digit(input logic [7:0] p, input int gap);
        seg_valid = 1'b0;
        repeat (gap) step();
        check("seg_ready_before_xfer", 32'(seg_ready), 32'd1);
        check("no_early_valid", 32'(value_valid), 32'd0);
        seg_in    = p;
        seg_valid = 1'b1;
        step();
        seg_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [5:0][7:0] pats, input int gap, input int hold,
                             input logic [ValueW-1:0] ev, input bit ee);
        for (int i = NumDigits - 1; i >= 0; i--) send_digit(pats[i], gap);
        check("valid_latency", 32'(value_valid), 32'd1);
        check("value", 32'(value), 32'(ev));
        check("err", 32'(err), 32'(ee));
        check("ready_low_done", 32'(seg_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", 32'(value_valid), 32'd1);
            check("hold_value", 32'(value), 32'(ev));
            check("hold_err", 32'(err), 32'(ee));
            check("hold_ready", 32'(seg_ready), 32'd0);
        end
        value_ready = 1'b1;
        step();
        value_ready = 1'b0;
        check("post_hs_valid", 32'(value_valid), 32'd0);
        check("post_hs_ready", 32'(seg_ready), 32'd1);
        check("post_hs_value", 32'(value), 32'd0);
        check("post_hs_err", 32'(err), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(value_valid), 32'd0);
        check({tag, "_ready"}, 32'(seg_ready), 32'd1);
        check({tag, "_value"}, 32'(value), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    function automatic logic [7:0] rand_pat();
        logic [7:0] p;
        if ($urandom_range(0, 4) == 0) p = 8'($urandom);
        else p = {1'($urandom), pat_tab[$urandom_range(0, 9)]};
        return p;
    endfunction

    initial begin
        logic [5:0][7:0]   pats;
        logic [ValueW-1:0] ev;
        bit                ee;

        vecs[0] = '{pats: 48'hC0C0C0F99982, gap: 8'd0, hold: 8'd0, ev: 20'd146,    ee: 1'b0};
        vecs[1] = '{pats: 48'h909090909090, gap: 8'd2, hold: 8'd0, ev: 20'hF423F,  ee: 1'b0};
        vecs[2] = '{pats: 48'hF9A455B09992, gap: 8'd0, hold: 8'd1, ev: 20'd120345, ee: 1'b1};
        vecs[3] = '{pats: 48'hC0C0C0C0A4F8, gap: 8'd1, hold: 8'd5, ev: 20'd27,     ee: 1'b0};

        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        check_idle("reset");

        foreach (vecs[k]) begin
            run_frame(vecs[k].pats, int'(vecs[k].gap), int'(vecs[k].hold),
                      vecs[k].ev, vecs[k].ee);
        end

        // Abort after 3 digits; clear coincides with a pending pattern and must win.
        send_digit(8'hF9, 0);
        send_digit(8'hA4, 0);
        send_digit(8'hB0, 0);
        seg_in    = 8'h99;
        seg_valid = 1'b1;
        clear     = 1'b1;
        step();
        clear     = 1'b0;
        seg_valid = 1'b0;
        check_idle("clear");
        run_frame(48'hF9A4B0999282, 0, 0, 20'd123456, 1'b0);

        // Reset after 4 digits discards the partial frame.
        for (int i = 0; i < 4; i++) send_digit(8'hF9, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("midreset");
`ifdef SEG_BLANK_ZERO_EN
        run_frame(48'hFFFFFFFFF9C0, 0, 0, 20'd10, 1'b0);
`else
        run_frame(48'hFFFFFFFFF9C0, 0, 0, 20'd10, 1'b1);
`endif

        // Clear while a result is waiting drops it.
        run_frame(48'hC0C0C0C0C0F9, 0, 0, 20'd1, 1'b0);
        for (int i = 0; i < NumDigits; i++) send_digit(8'h82, 0);
        clear       = 1'b1;
        value_ready = 1'b1;
        step();
        clear       = 1'b0;
        value_ready = 1'b0;
        check_idle("clear_done");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                int k = $urandom_range(1, NumDigits - 1);
                for (int i = 0; i < k; i++) send_digit(rand_pat(), $urandom_range(0, 2));
                seg_in    = rand_pat();
                seg_valid = 1'($urandom);
                clear     = 1'b1;
                step();
                clear     = 1'b0;
                seg_valid = 1'b0;
                check_idle("rand_clear");
            end
            for (int i = 0; i < NumDigits; i++) pats[i] = rand_pat();
            ref_frame(pats, ev, ee);
            run_frame(pats, $urandom_range(0, 2), $urandom_range(0, 3), ev, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_value_decoder.md
SEG_VALUE_DECODER -- requirements
Module: seg_value_decoder

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, meaning the number of seven-segment patterns per frame, most-significant first.
REQ-002 The block SHALL have parameter VALUE_W, default 20, meaning the width of the binary result.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 seg_in  input  8  active-low pattern {dp,g,f,e,d,c,b,a}.
REQ-006 seg_valid  input  1  seg_in holds a pattern.
REQ-007 seg_ready  output  1  block accepts a pattern this cycle.
REQ-008 clear  input  1  discard the partial frame.
REQ-009 value  output  VALUE_W  decoded binary result.
REQ-010 value_valid  output  1  value and err are valid.
REQ-011 value_ready  input  1  consumer accepts the result.
REQ-012 err  output  1  frame contained an undecodable pattern.

Function
REQ-013 FSM states SHALL be IDLE (no digit yet), ACCUM (1..NUM_DIGITS-1 digits taken) and DONE (result presented).
REQ-014 A pattern SHALL transfer exactly on a cycle with seg_valid and seg_ready both high; seg_valid gaps SHALL stall without changing state.
REQ-015 seg_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-016 Decode SHALL ignore bit 7 (dp) and match bits [6:0]: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
REQ-017 Each transfer SHALL update acc <= acc*10 + digit, computed modulo 2^VALUE_W; for NUM_DIGITS=6 and VALUE_W=20 the maximum 999999 does not overflow.
REQ-018 An undecodable pattern SHALL contribute digit 0 and set a sticky frame error flag.
REQ-019 A digit counter SHALL count transfers; the transfer of digit NUM_DIGITS SHALL move the FSM to DONE.
REQ-020 value_valid SHALL rise the cycle after the last transfer, which is a latency of 1 clock.
REQ-021 While in DONE, value and err SHALL hold stable until value_valid and value_ready are both high; the FSM SHALL then enter IDLE on the next cycle, with acc, counter and err flag cleared.
REQ-022 clear SHALL return the FSM to IDLE with acc, counter and error flag zeroed on the next cycle, from any state.
REQ-023 clear SHALL win over a simultaneous pattern transfer or result handshake.
REQ-024 value SHALL read 0 and err 0 whenever value_valid is 0.

Reset
REQ-025 When rst_n is low at a clock edge, the block SHALL go to IDLE and set acc=0, counter=0, value=0, value_valid=0, err=0 and seg_ready=1 on the next cycle.
REQ-026 A reset mid-frame SHALL discard all partial digits, and no result SHALL be emitted for that frame.

Configuration
REQ-027 With SEG_BLANK_ZERO_EN defined, the blank pattern 7Fh (all segments off) SHALL decode as digit 0 without error, for leading blanks.
REQ-028 Without SEG_BLANK_ZERO_EN defined, 7Fh SHALL be treated as undecodable per REQ-018.

Structure
REQ-029 A shared package seg_pkg SHALL hold the ten digit pattern constants, SEG_BLANK, the default VALUE_W and the FSM state enum.
REQ-030 Pattern-to-digit decoding SHALL live in combinational sub-module seg_digit_decode, with outputs digit[3:0] and invalid.

Verification
REQ-031 After reset, frame C0,C0,C0,F9,99,82 -> value=146, err=0, value_valid one cycle after the 6th transfer.
REQ-032 Six 90h patterns with 2-cycle seg_valid gaps -> value=999999 (F423Fh), err=0.
REQ-033 Frame F9,A4,00h?,B0,99,92 with third pattern 55h -> value=120345, err=1.
REQ-034 Hold value_ready=0 for 5 cycles after a result -> value, err and value_valid stay stable and seg_ready=0; on value_ready=1 -> IDLE next cycle and seg_ready=1.
REQ-035 Apply clear after 3 digits, then frame F9,A4,B0,99,92,82 -> value=123456, with no result emitted for the aborted frame.
REQ-036 Drive rst_n low after 4 digits, then frame FF,FF,FF,FF,F9,C0 -> value=10 and err=0 with SEG_BLANK_ZERO_EN defined; value=10 and err=1 without it.
